down_count_timer: RTL
=====================

// Module: down_count_timer
// PURPOSE
//   Loadable WIDTH-bit down-counter/timer that complements the up-counting T-flip-flop counter.
//   - load captures base; the block then decrements once per enabled cycle.
//   - tc pulses when the count expires; optional auto-reload gives a periodic tick.
//   - Sits beside the up-counter in the top-level wrapper and drives uo_out / status bits.
// PARAMETERS
//   WIDTH    8    counter and base width in bits (legal range 2..16)
// PORTS
//   clk          in   1      single clock; all state updates on posedge clk
//   reset        in   1      synchronous, active-high; sampled on posedge clk
//   load         in   1      capture base and start counting (level, sampled each cycle)
//   base         in   WIDTH  start / reload value
//   en           in   1      count enable; decrement only when high
//   auto_reload  in   1      1: reload base on expiry; 0: stop at zero
//   count        out  WIDTH  current counter value (registered)
//   tc           out  1      terminal-count pulse, one cycle wide (registered)
//   busy         out  1      high while in RUN (registered)
// BEHAVIOUR
//   Clock and reset
//   - One clock; reset is synchronous and active-high.
//   - Reset (highest priority): count=0, reload_reg=0, tc=0, busy=0, state=IDLE.
//   - Reset mid-RUN aborts with no tc pulse.
//   States
//   - IDLE (busy=0) and RUN (busy=1). tc is a registered output, not a separate state.
//   - busy reflects the state register.
//   Priority each edge: reset > load > decrement.
//   - load=1, base!=0:
//     - count<=base, reload_reg<=base, state<=RUN, tc<=0.
//     - en is ignored in the load cycle.
//   - load=1, base==0: count<=0, reload_reg<=0, state<=IDLE, tc<=0. No pulse.
//   - RUN, en=1, count>1: count<=count-1, tc<=0.
//   - RUN, en=1, count==1 (expiry):
//     - tc<=1 on the same edge that count updates.
//     - auto_reload=1: count<=reload_reg, stay RUN.
//     - auto_reload=0: count<=0, state<=IDLE.
//     - auto_reload is sampled only on the expiry edge.
//   - RUN, en=0: hold count, tc<=0.
//   - IDLE without load: hold count, tc<=0.
//     - Decrement never occurs in IDLE, so count never wraps below 0.
//   Timing
//   - One-shot: load base=N at edge k -> count=N after k.
//     With en held high, tc=1 and count=0 after edge k+N.
//   - Auto-reload: tc period = N enabled cycles. count sequence N..1, N..1, ...; 0 is never shown.
//   - load during RUN (including on the expiry cycle) restarts the count. tc is suppressed that cycle.
//   - load held high: the counter is re-captured every cycle and never decrements.
//   - Arithmetic is unsigned and modulo-free: count is always in [0, base].
//   - base is sampled only when load=1. Later changes to base have no effect until the next load.
// TESTING
//   1. Reset held 2 cycles mid-count (count=5, RUN)
//      -> count=0, busy=0, tc=0 on the next edge.
//      -> No tc appears afterwards.
//   2. load base=3, en=1, auto_reload=0
//      -> count 3,2,1,0 on successive edges.
//      -> tc=1 only with count=0. busy drops on that same edge.
//   3. load base=2, en=1, auto_reload=1 for 8 cycles
//      -> count 2,1,2,1,...
//      -> tc pulses on every second edge (each 1->2 reload).
//   4. load base=4, toggle en 1,0,1,0,...
//      -> count decrements only on en=1 cycles.
//      -> tc arrives after 4 enabled cycles.
//   5. load base=5 asserted on the cycle count==1, en=1
//      -> count=5, tc=0, busy=1. No expiry pulse.
//   6. load base=0
//      -> count=0, busy=0, tc=0.
//      -> Then en=1 for 10 cycles: count stays 0, no tc.

Source files
------------

// File: rtl/down_count_timer.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse and
// optional auto-reload for periodic ticks. Sits beside the up-counter in
// the top-level wrapper; all outputs come straight from registers.
module down_count_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] base,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    // Next-state: load outranks decrement; tc is only raised on a genuine expiry.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            // A zero base leaves nothing to count, so stay idle with no pulse.
            count_d  = base;
            reload_d = base;
            state_d  = (base != ZERO) ? RUN : IDLE;
        end else if (state_q == RUN && en) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else begin
                // Expiry: count is 1 here (RUN always holds a non-zero value).
                tc_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = ZERO;
                    state_d = IDLE;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);

endmodule
